// File: rtl/quarter_cycle_delay.sv
// quarter_cycle_delay
//   Programmable sample-delay line. For each new sample it presents the
//   current sample together with the sample D samples earlier, giving a
//   90-degree shifted copy when D = samples-per-cycle / 4.
//
// Ports
//   dclk       in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   sample_en  in   1   strobe: vin holds a new sample
//   vin        in   M   signed input sample
//   delay_cfg  in   AW  requested delay D in samples (0 is clamped to 1)
//   cfg_load   in   1   strobe: latch delay_cfg and restart priming
//   vout_0     out  M   current sample, aligned with vout_d
//   vout_d     out  M   sample delayed by D samples
//   out_valid  out  1   one-cycle pulse when vout_0/vout_d update
//   primed     out  1   level: buffer holds at least D samples
module quarter_cycle_delay #(
  parameter int unsigned M             = 14,
  parameter int unsigned AW            = 6,
  parameter int unsigned DEFAULT_DELAY = 50
) (
  input  logic          dclk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic [M-1:0]  vin,
  input  logic [AW-1:0] delay_cfg,
  input  logic          cfg_load,
  output logic [M-1:0]  vout_0,
  output logic [M-1:0]  vout_d,
  output logic          out_valid,
  output logic          primed
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;

  logic [M-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] fill_cnt_q, fill_cnt_d;
  logic [AW-1:0] dly_q, dly_d;
  logic [AW-1:0] rd_addr;

  logic [M-1:0]  vout_0_q, vout_0_d;
  logic [M-1:0]  vout_d_q, vout_d_d;
  logic          out_valid_q, out_valid_d;
  logic          primed_q, primed_d;

  // A sample that produces output: already running, or the sample that
  // completes priming. A cfg_load in the same cycle always restarts the fill.
  logic          fill_done;
  logic          run_sample;

  // Modulo-DEPTH subtraction; D <= DEPTH-1 keeps rd_addr away from wr_ptr_q.
  assign rd_addr    = AW'(wr_ptr_q - dly_q);
  assign fill_done  = (fill_cnt_q == dly_q);
  assign run_sample = sample_en && !cfg_load &&
                      ((state_q == ST_RUN) || fill_done);

  // State register
  always_ff @(posedge dclk) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = ST_FILL;
    end else if (sample_en && (state_q == ST_FILL) && fill_done) begin
      state_d = ST_RUN;
    end
  end

  // Output next values
  always_comb begin
    vout_0_d    = vout_0_q;
    vout_d_d    = vout_d_q;
    out_valid_d = 1'b0;
    primed_d    = (state_d == ST_RUN);
    if (run_sample) begin
      vout_0_d    = vin;
      vout_d_d    = mem_q[rd_addr];
      out_valid_d = 1'b1;
    end
  end

  // Pointer, fill counter and delay next values
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    dly_d      = dly_q;
    if (sample_en) begin
      wr_ptr_d = AW'(wr_ptr_q + 1'b1);
    end
    if (cfg_load) begin
      dly_d      = (delay_cfg == '0) ? AW'(1) : delay_cfg;
      // A sample arriving with cfg_load is the first of the new fill.
      fill_cnt_d = sample_en ? AW'(1) : '0;
    end else if (sample_en && (state_q == ST_FILL) && !fill_done) begin
      fill_cnt_d = AW'(fill_cnt_q + 1'b1);
    end
  end

  // Control and output registers
  always_ff @(posedge dclk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      dly_q       <= AW'(DEFAULT_DELAY);
      vout_0_q    <= '0;
      vout_d_q    <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      dly_q       <= dly_d;
      vout_0_q    <= vout_0_d;
      vout_d_q    <= vout_d_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
    end
  end

  // Sample buffer; contents are don't-care after reset, so no reset here.
  always_ff @(posedge dclk) begin
    if (sample_en) begin
      mem_q[wr_ptr_q] <= vin;
    end
  end

  assign vout_0    = vout_0_q;
  assign vout_d    = vout_d_q;
  assign out_valid = out_valid_q;
  assign primed    = primed_q;

endmodule
